// File: rtl/jtcps_obj_pkg.sv
// Shared definitions for the object line scanner: FSM encoding,
// draw-queue entry layout and the default scan-start position.
package jtcps_obj_pkg;

    localparam logic [8:0] HSTART_DEF = 9'h1d0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_EVAL   = 2'd2,
        ST_EXPAND = 2'd3
    } scan_state_e;

    localparam int CODE_W = 16;
    localparam int ATTR_W = 16;
    localparam int HPOS_W = 9;
    localparam int PRIO_W = 3;
    localparam int BANK_W = 2;

    // One tile ready for the renderer
    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic [ATTR_W-1:0] attr;
        logic [HPOS_W-1:0] hpos;
        logic [PRIO_W-1:0] prio;
        logic [BANK_W-1:0] bank;
    } obj_entry_t;

    localparam int ENTRY_W = $bits(obj_entry_t);

endpackage

// File: rtl/jtcps_obj_scanq_if.sv
// Draw-queue to renderer handshake. master = scanner, slave = renderer.
interface jtcps_obj_scanq_if;
    logic        dr_valid;
    logic        dr_ready;
    logic [15:0] dr_code;
    logic [15:0] dr_attr;
    logic [8:0]  dr_hpos;
    logic [2:0]  dr_prio;
    logic [1:0]  dr_bank;

    modport master (output dr_valid, dr_code, dr_attr, dr_hpos, dr_prio, dr_bank,
                    input  dr_ready);
    modport slave  (input  dr_valid, dr_code, dr_attr, dr_hpos, dr_prio, dr_bank,
                    output dr_ready);
endinterface

// File: rtl/jtcps_obj_fifo.sv
// First-word fall-through queue with synchronous flush. Output data reads
// as zero while empty so the renderer never sees stale entries.
module jtcps_obj_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
)(
    input  logic          rst,
    input  logic          clk,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [DW-1:0] din_i,
    input  logic          pop_i,
    output logic [DW-1:0] dout_o,
    output logic          valid_o,
    output logic          full_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [PW:0]   cnt_q;
    logic          push_ok, pop_ok;

    assign valid_o = cnt_q != '0;
    assign full_o  = cnt_q == (PW+1)'(DEPTH);
    assign pop_ok  = pop_i & valid_o;
    // A full queue still accepts a push when the head leaves in the same cycle
    assign push_ok = push_i & (~full_o | pop_ok);
    assign dout_o  = valid_o ? mem_q[rd_q] : '0;

    // Storage array, written at the tail
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= din_i;
    end

    // Pointers and occupancy; flush empties the queue at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) wr_q <= wr_q + PW'(1);
            if (pop_ok)  rd_q <= rd_q + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

// File: rtl/jtcps_obj_scanq.sv
// Object table line scanner: walks the table at each line start, finds the
// objects crossing the render line and queues their tiles for drawing.
// Optional per-line tile limit: define JTCPS_OBJ_LIMIT_EN.
module jtcps_obj_scanq
    import jtcps_obj_pkg::*;
#(
    parameter int         AW      = 10,
    parameter int         QDEPTH  = 4,
    parameter logic [8:0] HSTART  = HSTART_DEF,
    parameter logic [7:0] MAXTILE = 8'd128
)(
    input  logic          rst,
    input  logic          clk,
    input  logic          flip_i,
    input  logic [8:0]    vrender1_i,
    input  logic [8:0]    hdump_i,
    input  logic [9:0]    off_x_i,
    input  logic [9:0]    off_y_i,
    output logic [AW-1:0] table_addr_o,
    input  logic [15:0]   table_x_i,
    input  logic [15:0]   table_y_i,
    input  logic [15:0]   table_code_i,
    input  logic [15:0]   table_attr_i,
    output logic          line_o,
    output logic          ovf_o,
    jtcps_obj_scanq_if.master dr
);
    scan_state_e   state_q;
    logic [AW-1:0] addr_q;
    logic          line_q, hs_q;
    logic [8:0]    vrf_q;
    logic [9:0]    objx_q;
    logic [15:0]   code_q;
    logic [7:0]    attrl_q;
    logic [3:0]    size_q, vsub_q, n_q;
    logic [2:0]    prio_q;
    logic [1:0]    bank_q;

    logic          start, hit, vflip, end_ent, last_ent, last_n;
    logic          visible, pop, space, push, step, full;
    logic [9:0]    obj_x, obj_y, dy, effx;
    logic [4:0]    hgt;
    logic [3:0]    row, subn;
    obj_entry_t    ent, head;

    assign start    = (hdump_i == HSTART) & ~hs_q;

    // Object evaluation, valid in EVAL while table data is on the bus
    assign obj_x    = table_x_i[9:0] + 10'h40 - (table_attr_i[7] ? 10'd0 : off_x_i);
    assign obj_y    = table_y_i[9:0] + 10'h10 - (table_attr_i[7] ? 10'd0 : off_y_i);
    assign dy       = {1'b0, vrf_q} - obj_y;
    assign hgt      = {1'b0, table_attr_i[15:12]} + 5'd1;
    assign hit      = dy < {1'b0, hgt, 4'd0};
    assign vflip    = table_attr_i[6];
    assign row      = vflip ? table_attr_i[15:12] - dy[7:4] : dy[7:4];
    assign end_ent  = table_y_i[15] | (table_attr_i[15:8] == 8'hff);
    assign last_ent = &addr_q;

    // Tile expansion; off-screen tiles are skipped without waiting for room
    assign subn     = attrl_q[5] ? size_q - n_q : n_q;
    assign effx     = objx_q + {2'b0, subn, 4'd0};
    assign visible  = ~effx[9];
    assign pop      = dr.dr_valid & dr.dr_ready;
    assign space    = ~full | pop;
    assign push     = (state_q == ST_EXPAND) & visible & space & ~start;
    assign step     = (state_q == ST_EXPAND) & (space | ~visible);
    assign last_n   = n_q == size_q;

    assign ent.code = code_q + {12'd0, n_q};
    assign ent.attr = {4'd0, vsub_q, attrl_q};
    assign ent.hpos = effx[8:0] - 9'd1;
    assign ent.prio = prio_q;
    assign ent.bank = bank_q;

`ifdef JTCPS_OBJ_LIMIT_EN
    logic [8:0] cnt_q;
    logic       ovf_q, lim_hit;
    assign lim_hit = push & ((cnt_q + 9'd1) == {1'b0, MAXTILE});
    assign ovf_o   = ovf_q;
`else
    logic unused_max;
    assign unused_max = ^MAXTILE;
    assign ovf_o      = 1'b0;
`endif

    logic unused_bits;
    assign unused_bits = ^{table_x_i[12:10], table_y_i[12:10]};

    // Scan sequencer: line start restarts the walk from entry 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            line_q  <= 1'b0;
            hs_q    <= 1'b0;
            vrf_q   <= '0;
            objx_q  <= '0;
            code_q  <= '0;
            attrl_q <= '0;
            size_q  <= '0;
            vsub_q  <= '0;
            n_q     <= '0;
            prio_q  <= '0;
            bank_q  <= '0;
`ifdef JTCPS_OBJ_LIMIT_EN
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            hs_q <= hdump_i == HSTART;
            if (start) begin
                line_q  <= ~line_q;
                vrf_q   <= vrender1_i ^ {1'b0, {8{flip_i}}};
                addr_q  <= '0;
                state_q <= ST_READ;
`ifdef JTCPS_OBJ_LIMIT_EN
                cnt_q   <= '0;
                ovf_q   <= 1'b0;
`endif
            end else begin
                case (state_q)
                    ST_READ: state_q <= ST_EVAL;
                    ST_EVAL: begin
                        if (end_ent) begin
                            state_q <= ST_IDLE;
                        end else if (hit) begin
                            objx_q  <= obj_x;
                            code_q  <= table_code_i + {8'd0, row, 4'd0};
                            attrl_q <= table_attr_i[7:0];
                            size_q  <= table_attr_i[11:8];
                            vsub_q  <= dy[3:0] ^ {4{vflip}};
                            prio_q  <= table_x_i[15:13];
                            bank_q  <= table_y_i[14:13];
                            n_q     <= '0;
                            state_q <= ST_EXPAND;
                        end else if (last_ent) begin
                            state_q <= ST_IDLE;
                        end else begin
                            addr_q  <= addr_q + AW'(1);
                            state_q <= ST_READ;
                        end
                    end
                    ST_EXPAND: begin
                        if (step) begin
                            if (last_n) begin
                                if (last_ent) begin
                                    state_q <= ST_IDLE;
                                end else begin
                                    addr_q  <= addr_q + AW'(1);
                                    state_q <= ST_READ;
                                end
                            end else begin
                                n_q <= n_q + 4'd1;
                            end
`ifdef JTCPS_OBJ_LIMIT_EN
                            if (push) cnt_q <= cnt_q + 9'd1;
                            if (lim_hit) begin
                                ovf_q   <= 1'b1;
                                state_q <= ST_IDLE;
                            end
`endif
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    jtcps_obj_fifo #(.DW(ENTRY_W), .DEPTH(QDEPTH)) u_fifo (
        .rst     (rst),
        .clk     (clk),
        .flush_i (start),
        .push_i  (push),
        .din_i   (ent),
        .pop_i   (pop),
        .dout_o  (head),
        .valid_o (dr.dr_valid),
        .full_o  (full)
    );

    assign dr.dr_code    = head.code;
    assign dr.dr_attr    = head.attr;
    assign dr.dr_hpos    = head.hpos;
    assign dr.dr_prio    = head.prio;
    assign dr.dr_bank    = head.bank;
    assign table_addr_o  = addr_q;
    assign line_o        = line_q;
endmodule

// File: tb/tb_jtcps_obj_scanq.sv
// Directed bench for jtcps_obj_scanq: single-object vector table plus
// hand-written backpressure, restart, terminator, reset and limit sequences.
module tb_jtcps_obj_scanq;
    localparam logic [8:0] HST = 9'h1d0;
`ifdef JTCPS_OBJ_LIMIT_EN
    localparam bit LIM = 1'b1;
`else
    localparam bit LIM = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b1, flip = 1'b0;
    logic [8:0]  vrender1 = '0, hdump = '0;
    logic [9:0]  off_x = '0, off_y = '0;
    logic [9:0]  taddr;
    logic [15:0] tx, ty, tcode, tattr;
    logic        line, ovf;
    logic [15:0] mx [1024], my [1024], mc [1024], ma [1024];

    jtcps_obj_scanq_if drif ();

    jtcps_obj_scanq #(.AW(10), .QDEPTH(4), .HSTART(HST), .MAXTILE(8'd4)) dut (
        .rst(rst), .clk(clk), .flip_i(flip), .vrender1_i(vrender1), .hdump_i(hdump),
        .off_x_i(off_x), .off_y_i(off_y), .table_addr_o(taddr),
        .table_x_i(tx), .table_y_i(ty), .table_code_i(tcode), .table_attr_i(tattr),
        .line_o(line), .ovf_o(ovf), .dr(drif.master)
    );

    always #5 clk = ~clk;

    // Object table RAM, one clock read latency
    always @(posedge clk) begin
        tx    <= mx[taddr];
        ty    <= my[taddr];
        tcode <= mc[taddr];
        tattr <= ma[taddr];
    end

    typedef struct {
        logic [15:0] code, attr;
        logic [8:0]  hpos;
        logic [2:0]  prio;
        logic [1:0]  bank;
    } rec_t;
    rec_t got[$];

    // Record every accepted transfer
    always @(negedge clk) begin
        if (!rst && drif.dr_valid && drif.dr_ready)
            got.push_back('{drif.dr_code, drif.dr_attr, drif.dr_hpos, drif.dr_prio, drif.dr_bank});
    end

    typedef struct {
        logic [15:0] x, y, code, attr;
        logic [8:0]  vr;
        logic [9:0]  ox, oy;
        logic        flip;
        int          n;
        logic [15:0] c0;
        logic [8:0]  h0;
        logic [15:0] a0;
        logic [2:0]  p0;
        logic [1:0]  b0;
        logic [15:0] cl;
        logic [8:0]  hl;
    } vec_t;
    vec_t vecs[12];

    int   total = 0, bad = 0;
    logic exp_line = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic clr_tab();
        for (int i = 0; i < 8; i++) begin
            mx[i] = '0; my[i] = 16'h8000; mc[i] = '0; ma[i] = '0;
        end
    endtask

    task automatic put(input int i, input logic [15:0] x, y, c, a);
        mx[i] = x; my[i] = y; mc[i] = c; ma[i] = a;
    endtask

    // One-cycle pulse of the scan-start position; checks land at +2 after the start edge
    task automatic trigger();
        @(posedge clk); #1 hdump = HST;
        @(posedge clk); #1 hdump = '0;
        exp_line = ~exp_line;
        #1;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        v = vecs[idx];
        clr_tab();
        put(0, v.x, v.y, v.code, v.attr);
        off_x = v.ox; off_y = v.oy; flip = v.flip; vrender1 = v.vr;
        drif.dr_ready = 1'b1;
        got.delete();
        trigger();
        cyc(80);
        chk($sformatf("v%0d_line", idx), line, exp_line);
        chk($sformatf("v%0d_ovf", idx), ovf, 0);
        chk($sformatf("v%0d_cnt", idx), got.size(), v.n);
        if (got.size() > 0) begin
            chk($sformatf("v%0d_code0", idx), got[0].code, v.c0);
            chk($sformatf("v%0d_hpos0", idx), got[0].hpos, v.h0);
            chk($sformatf("v%0d_attr0", idx), got[0].attr, v.a0);
            chk($sformatf("v%0d_prio0", idx), got[0].prio, v.p0);
            chk($sformatf("v%0d_bank0", idx), got[0].bank, v.b0);
            chk($sformatf("v%0d_codeL", idx), got[got.size()-1].code, v.cl);
            chk($sformatf("v%0d_hposL", idx), got[got.size()-1].hpos, v.hl);
        end
    endtask

    initial begin
        //           x        y        code     attr     vr      ox     oy     fl  n  c0       h0      a0       p  b  cl       hl
        vecs[0]  = '{16'h0010,16'h0020,16'h1234,16'h0000,9'h035,10'h00,10'h00,1'b0,1,16'h1234,9'h04f,16'h0500,0,0,16'h1234,9'h04f};
        vecs[1]  = '{16'h0010,16'h0020,16'h1000,16'h0220,9'h035,10'h00,10'h00,1'b0,3,16'h1000,9'h06f,16'h0520,0,0,16'h1002,9'h04f};
        vecs[2]  = '{16'h0010,16'h0020,16'h2000,16'h1040,9'h043,10'h00,10'h00,1'b0,1,16'h2000,9'h04f,16'h0c40,0,0,16'h2000,9'h04f};
        vecs[3]  = '{16'h0010,16'h0020,16'h2000,16'h1000,9'h043,10'h00,10'h00,1'b0,1,16'h2010,9'h04f,16'h0300,0,0,16'h2010,9'h04f};
        vecs[4]  = '{16'h0010,16'h0020,16'h2000,16'h0000,9'h045,10'h00,10'h00,1'b0,0,16'h0000,9'h000,16'h0000,0,0,16'h0000,9'h000};
        vecs[5]  = '{16'h0010,16'h0020,16'h0055,16'h0000,9'h02a,10'h20,10'h08,1'b0,1,16'h0055,9'h02f,16'h0200,0,0,16'h0055,9'h02f};
        vecs[6]  = '{16'h0010,16'h0020,16'h0066,16'h0080,9'h035,10'h20,10'h08,1'b0,1,16'h0066,9'h04f,16'h0580,0,0,16'h0066,9'h04f};
        vecs[7]  = '{16'h0010,16'h0020,16'h0077,16'h0000,9'h0ca,10'h00,10'h00,1'b1,1,16'h0077,9'h04f,16'h0500,0,0,16'h0077,9'h04f};
        vecs[8]  = '{16'h01a0,16'h0020,16'h0300,16'h0300,9'h035,10'h00,10'h00,1'b0,2,16'h0300,9'h1df,16'h0500,0,0,16'h0301,9'h1ef};
        vecs[9]  = '{16'ha010,16'h4020,16'h0001,16'h0000,9'h035,10'h00,10'h00,1'b0,1,16'h0001,9'h04f,16'h0500,5,2,16'h0001,9'h04f};
        vecs[10] = '{16'h0010,16'h0020,16'hffff,16'h0100,9'h035,10'h00,10'h00,1'b0,2,16'hffff,9'h04f,16'h0500,0,0,16'h0000,9'h05f};
        vecs[11] = '{16'h0010,16'h0020,16'h0088,16'hff00,9'h035,10'h00,10'h00,1'b0,0,16'h0000,9'h000,16'h0000,0,0,16'h0000,9'h000};

        for (int i = 0; i < 1024; i++) begin
            mx[i] = '0; my[i] = 16'h8000; mc[i] = '0; ma[i] = '0;
        end
        drif.dr_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_valid", drif.dr_valid, 0);
        chk("rst_line", line, 0);
        chk("rst_addr", taddr, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_code", drif.dr_code, 0);
        chk("rst_hpos", drif.dr_hpos, 0);

        for (int i = 0; i < 12; i++) run_vec(i);

        // Backpressure: 6 tiles against a 4-deep queue
        begin
            int en;
            en = LIM ? 4 : 6;
            clr_tab();
            put(0, 16'h0010, 16'h0020, 16'h3000, 16'h0500);
            vrender1 = 9'h035; off_x = '0; off_y = '0; flip = 1'b0;
            drif.dr_ready = 1'b0;
            got.delete();
            trigger();
            cyc(20);
            chk("bp_held_valid", drif.dr_valid, 1);
            chk("bp_held_code", drif.dr_code, 16'h3000);
            chk("bp_none_out", got.size(), 0);
            @(posedge clk); #1 drif.dr_ready = 1'b1;
            cyc(40);
            chk("bp_cnt", got.size(), en);
            for (int i = 0; i < en && i < got.size(); i++) begin
                chk($sformatf("bp_code%0d", i), got[i].code, 16'h3000 + 16'(i));
                chk($sformatf("bp_hpos%0d", i), got[i].hpos, 9'h04f + 9'(16 * i));
            end
        end

        // Restart while expanding entry 2 with the queue stalled
        clr_tab();
        put(0, 16'h0010, 16'h0100, 16'h0000, 16'h0000);
        put(1, 16'h0010, 16'h0100, 16'h0000, 16'h0000);
        put(2, 16'h0010, 16'h0020, 16'h4000, 16'h0f00);
        drif.dr_ready = 1'b0;
        trigger();
        cyc(15);
        chk("rs_pre_addr", taddr, 2);
        chk("rs_pre_valid", drif.dr_valid, 1);
        got.delete();
        trigger();
        chk("rs_valid", drif.dr_valid, 0);
        chk("rs_line", line, exp_line);
        chk("rs_addr", taddr, 0);
        @(posedge clk); #1 drif.dr_ready = 1'b1;
        cyc(80);
        chk("rs_cnt", got.size(), LIM ? 4 : 16);
        if (got.size() > 0) chk("rs_code0", got[0].code, 16'h4000);

        // Terminator at entry 3: entry 4 must not be reached
        clr_tab();
        for (int i = 0; i < 3; i++) put(i, 16'h0010, 16'h0020, 16'h0010 + 16'(i), 16'h0000);
        put(4, 16'h0010, 16'h0020, 16'h0014, 16'h0000);
        got.delete();
        trigger();
        cyc(60);
        chk("term_cnt", got.size(), 3);
        chk("term_addr", taddr, 3);
        for (int i = 0; i < 3 && i < got.size(); i++)
            chk($sformatf("term_code%0d", i), got[i].code, 16'h0010 + 16'(i));

        // Reset mid-scan with a full queue
        clr_tab();
        put(0, 16'h0010, 16'h0020, 16'h6000, 16'h0f00);
        drif.dr_ready = 1'b0;
        trigger();
        cyc(12);
        chk("mr_pre_valid", drif.dr_valid, 1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        exp_line = 1'b0;
        drif.dr_ready = 1'b1;
        #1;
        chk("mr_valid", drif.dr_valid, 0);
        chk("mr_line", line, 0);
        chk("mr_addr", taddr, 0);
        chk("mr_code", drif.dr_code, 0);
        cyc(1);
        chk("mr_valid1", drif.dr_valid, 0);

        // Per-line tile limit (10 tiles, limit 4 when enabled)
        clr_tab();
        put(0, 16'h0010, 16'h0020, 16'h5000, 16'h0900);
        got.delete();
        trigger();
        cyc(80);
        chk("lim_cnt", got.size(), LIM ? 4 : 10);
        chk("lim_ovf", ovf, LIM ? 1 : 0);
        run_vec(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
